ddr_burst_responder: RTL and testbench
======================================

// Module: ddr_burst_responder
// PURPOSE
//  Responder end of the FIFO-controller <-> DDR handshake: takes level ddr_wr_req/ddr_rd_req plus
//  burst address/length from the dcfifo controller, runs the burst on the DDR2 controller local
//  (Avalon-style, 1 word per command) port, emits per-word ddr_wr_ack/ddr_rd_ack (FIFO rd/wr
//  strobes) and a one-cycle *_finish pulse per burst. Sits between dcfifo controller and DDR2 IP.
// PARAMETERS
//  ADDR_W     25  word address width (ddr_wraddr/ddr_rdaddr/local_address)
//  DATA_W     32  data width
//  LEN_W      10  burst length width (wr_length/rd_length)
//  HOLD_CYC   2   idle cycles after a finish pulse before a new request is sampled (>=1)
// PORTS
//  clk_ref            in  1       controller clock; all logic on rising edge
//  rst_n              in  1       asynchronous active-low reset
//  local_init_done    in  1       DDR calibration done; requests ignored while 0
//  ddr_wr_req         in  1       write burst request (level)
//  ddr_wraddr         in  ADDR_W  write burst base address
//  wr_length          in  LEN_W   write burst length in words
//  ddr_wr_ack         out 1       write-FIFO read strobe; data valid on ddr_din next cycle
//  ddr_din            in  DATA_W  write-FIFO output (normal, non-show-ahead)
//  ddr_wr_finish      out 1       1-cycle pulse: last write word accepted by DDR
//  ddr_rd_req         in  1       read burst request (level)
//  ddr_rdaddr         in  ADDR_W  read burst base address
//  rd_length          in  LEN_W   read burst length in words
//  ddr_rd_ack         out 1       read-FIFO write strobe, qualifies ddr_dout
//  ddr_dout           out DATA_W  read data to read FIFO
//  ddr_rd_finish      out 1       1-cycle pulse: last read word delivered
//  local_address      out ADDR_W  DDR word address
//  local_write_req    out 1       DDR write command
//  local_read_req     out 1       DDR read command
//  local_wdata        out DATA_W  DDR write data
//  local_ready        in  1       DDR accepts the presented command this cycle
//  local_rdata        in  DATA_W  DDR read data
//  local_rdata_valid  in  1       qualifies local_rdata
//  busy               out 1       state != IDLE
//  protocol_err       out 1       sticky: local_rdata_valid outside RD_CMD/RD_WAIT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters/buffer cleared; reset mid-burst aborts silently.
//  States: IDLE -> WR_BURST | RD_CMD -> RD_WAIT -> HOLD -> IDLE.
//  IDLE: if local_init_done: ddr_wr_req wins over ddr_rd_req when both high. Latch address and
//   length at entry; later changes to these inputs are ignored until next IDLE.
//  Length 0: no local commands, no acks; finish pulse next cycle, then HOLD.
//  WR_BURST: 2-entry write buffer. ddr_wr_ack=1 when acked<len and buf_cnt+inflight-pop<2
//   (pop=local_write_req&local_ready); ddr_din captured into buffer the cycle after each ack.
//   local_write_req=buffer non-empty, local_wdata=buffer head, local_address=base+issued
//   (mod 2^ADDR_W). Held stable until local_ready. Peak 1 word/cycle with local_ready high.
//  ddr_wr_finish registered: pulses the cycle after the last word's local_ready, then HOLD.
//  RD_CMD: local_read_req=1, local_address=base+issued; issued++ on local_ready; -> RD_WAIT after
//   len-th accept. Returned words counted in both RD_CMD and RD_WAIT.
//  ddr_rd_ack/ddr_dout = local_rdata_valid/local_rdata registered (latency 1, order preserved).
//  ddr_rd_finish pulses the cycle after the len-th ddr_rd_ack, then HOLD.
//  HOLD: HOLD_CYC cycles with requests ignored (initiator updates address/FIFO levels on finish).
//  local_write_req and local_read_req never both 1. local_init_done falling mid-burst: burst
//   completes; only new requests blocked. Counters LEN_W+1 bits; no overflow for len<=2^LEN_W-1.
//  protocol_err: set on stray local_rdata_valid (data dropped, no ack); cleared only by reset.
// TESTING
//  wr_req, addr=0x100, len=8, local_ready=1 -> 8 acks, addresses 0x100..0x107 in order with
//   matching data, ddr_wr_finish 1 cycle after last accept, busy low HOLD_CYC cycles later.
//  Same write, local_ready toggling 1-of-3 -> no word lost/duplicated, never >2 acks unconsumed.
//  rd_req, addr=0x200, len=16, rdata_valid 5 cycles after each cmd -> 16 ddr_rd_ack with data
//   in order, ddr_rd_finish the cycle after the 16th ack.
//  wr_req and rd_req raised same cycle -> write burst first; read starts after HOLD if still
//   requested; req held high through HOLD -> no second burst sampled before HOLD ends.
//  len=0 -> no local commands, finish pulse next cycle; local_init_done=0 -> requests ignored.
//  rst_n low mid-read (8 of 16 returned) -> all outputs 0 immediately, IDLE; stray
//   local_rdata_valid in IDLE -> protocol_err=1, no ddr_rd_ack.

Source files
------------

// File: rtl/ddr_burst_responder.sv
// Responder side of the dcfifo-controller <-> DDR2 local-port burst handshake.
// Runs one write or read burst per request, one word per local command, and
// reports per-word FIFO strobes plus a single finish pulse per burst.
module ddr_burst_responder #(
    parameter int unsigned ADDR_W   = 25,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LEN_W    = 10,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              local_init_done,
    input  logic              ddr_wr_req,
    input  logic [ADDR_W-1:0] ddr_wraddr,
    input  logic [LEN_W-1:0]  wr_length,
    output logic              ddr_wr_ack,
    input  logic [DATA_W-1:0] ddr_din,
    output logic              ddr_wr_finish,
    input  logic              ddr_rd_req,
    input  logic [ADDR_W-1:0] ddr_rdaddr,
    input  logic [LEN_W-1:0]  rd_length,
    output logic              ddr_rd_ack,
    output logic [DATA_W-1:0] ddr_dout,
    output logic              ddr_rd_finish,
    output logic [ADDR_W-1:0] local_address,
    output logic              local_write_req,
    output logic              local_read_req,
    output logic [DATA_W-1:0] local_wdata,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic              busy,
    output logic              protocol_err
);

    localparam int unsigned CntW  = LEN_W + 1;
    localparam int unsigned HoldW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StWrBurst, StRdCmd, StRdWait, StHold} state_e;

    state_e                       state_q, state_d;
    logic [ADDR_W-1:0]            base_q, base_d;
    logic [CntW-1:0]              len_q, len_d;
    logic [CntW-1:0]              issued_q, issued_d;
    logic [CntW-1:0]              acked_q, acked_d;
    logic [CntW-1:0]              rcvd_q, rcvd_d;
    logic [HoldW-1:0]             hold_q, hold_d;
    logic                         wr_finish_q, wr_finish_d;
    logic                         rd_finish_q, rd_finish_d;

    // Two-entry write buffer fed one cycle after each FIFO read strobe
    logic [1:0][DATA_W-1:0]       wbuf_q;
    logic                         wr_ptr_q, rd_ptr_q;
    logic [1:0]                   buf_cnt_q;
    logic                         inflight_q;
    logic                         wr_pop;
    logic [2:0]                   wr_occ;

    logic                         rd_window;
    logic                         rd_ack_q;
    logic [DATA_W-1:0]            rd_data_q;
    logic                         perr_q;

    assign wr_pop    = (state_q == StWrBurst) && (buf_cnt_q != 2'd0) && local_ready;
    // Words already owned by the buffer once this cycle's pop leaves
    assign wr_occ    = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, wr_pop};
    assign rd_window = (state_q == StRdCmd) || (state_q == StRdWait);

    assign local_wdata   = local_write_req ? wbuf_q[rd_ptr_q] : '0;
    assign ddr_wr_finish = wr_finish_q;
    assign ddr_rd_finish = rd_finish_q;
    assign ddr_rd_ack    = rd_ack_q;
    assign ddr_dout      = rd_data_q;
    assign busy          = (state_q != StIdle);
    assign protocol_err  = perr_q;

    // Burst sequencing: next state, counters and local command outputs
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        issued_d        = issued_q;
        acked_d         = acked_q;
        rcvd_d          = rcvd_q;
        hold_d          = hold_q;
        wr_finish_d     = 1'b0;
        rd_finish_d     = 1'b0;
        ddr_wr_ack      = 1'b0;
        local_write_req = 1'b0;
        local_read_req  = 1'b0;
        local_address   = '0;

        unique case (state_q)
            StIdle: begin
                issued_d = '0;
                acked_d  = '0;
                rcvd_d   = '0;
                hold_d   = '0;
                if (local_init_done && ddr_wr_req) begin
                    base_d = ddr_wraddr;
                    len_d  = CntW'(wr_length);
                    if (wr_length == '0) begin
                        wr_finish_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        state_d = StWrBurst;
                    end
                end else if (local_init_done && ddr_rd_req) begin
                    base_d = ddr_rdaddr;
                    len_d  = CntW'(rd_length);
                    if (rd_length == '0) begin
                        rd_finish_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        state_d = StRdCmd;
                    end
                end
            end
            StWrBurst: begin
                local_write_req = (buf_cnt_q != 2'd0);
                local_address   = base_q + ADDR_W'(issued_q);
                ddr_wr_ack      = (acked_q < len_q) && (wr_occ < 3'd2);
                if (ddr_wr_ack) begin
                    acked_d = acked_q + CntW'(1);
                end
                if (wr_pop) begin
                    issued_d = issued_q + CntW'(1);
                    if (issued_q + CntW'(1) == len_q) begin
                        wr_finish_d = 1'b1;
                        state_d     = StHold;
                    end
                end
            end
            StRdCmd, StRdWait: begin
                if (state_q == StRdCmd) begin
                    local_read_req = 1'b1;
                    local_address  = base_q + ADDR_W'(issued_q);
                    if (local_ready) begin
                        issued_d = issued_q + CntW'(1);
                        if (issued_q + CntW'(1) == len_q) begin
                            state_d = StRdWait;
                        end
                    end
                end
                if (rd_ack_q) begin
                    rcvd_d = rcvd_q + CntW'(1);
                    if (rcvd_q + CntW'(1) == len_q) begin
                        rd_finish_d = 1'b1;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                hold_d = hold_q + HoldW'(1);
                if (hold_q == HoldW'(HOLD_CYC - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and burst bookkeeping registers
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            acked_q     <= '0;
            rcvd_q      <= '0;
            hold_q      <= '0;
            wr_finish_q <= 1'b0;
            rd_finish_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            acked_q     <= acked_d;
            rcvd_q      <= rcvd_d;
            hold_q      <= hold_d;
            wr_finish_q <= wr_finish_d;
            rd_finish_q <= rd_finish_d;
        end
    end

    // Write buffer: capture FIFO data a cycle after each ack, drain on accept
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            buf_cnt_q  <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= ddr_wr_ack;
            if (inflight_q) begin
                wbuf_q[wr_ptr_q] <= ddr_din;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (wr_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_q + {1'b0, inflight_q} - {1'b0, wr_pop};
        end
    end

    // Read return path: one-cycle registered forward; stray data flags an error
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            rd_ack_q <= local_rdata_valid && rd_window;
            if (local_rdata_valid && rd_window) begin
                rd_data_q <= local_rdata;
            end
            if (local_rdata_valid && !rd_window) begin
                perr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Self-checking bench for ddr_burst_responder: randomized bursts against a
// queue-based model of the write FIFO and the DDR local port.
module tb_ddr_burst_responder;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 32;
    localparam int LEN_W    = 10;
    localparam int HOLD_CYC = 2;
    localparam int Budget   = 2000;

    logic              clk_ref = 1'b0;
    logic              rst_n = 1'b0;
    logic              local_init_done = 1'b0;
    logic              ddr_wr_req = 1'b0;
    logic [ADDR_W-1:0] ddr_wraddr = '0;
    logic [LEN_W-1:0]  wr_length = '0;
    logic              ddr_wr_ack;
    logic [DATA_W-1:0] ddr_din = '0;
    logic              ddr_wr_finish;
    logic              ddr_rd_req = 1'b0;
    logic [ADDR_W-1:0] ddr_rdaddr = '0;
    logic [LEN_W-1:0]  rd_length = '0;
    logic              ddr_rd_ack;
    logic [DATA_W-1:0] ddr_dout;
    logic              ddr_rd_finish;
    logic [ADDR_W-1:0] local_address;
    logic              local_write_req;
    logic              local_read_req;
    logic [DATA_W-1:0] local_wdata;
    logic              local_ready = 1'b0;
    logic [DATA_W-1:0] local_rdata = '0;
    logic              local_rdata_valid = 1'b0;
    logic              busy;
    logic              protocol_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    ddr_burst_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk_ref          (clk_ref),
        .rst_n            (rst_n),
        .local_init_done  (local_init_done),
        .ddr_wr_req       (ddr_wr_req),
        .ddr_wraddr       (ddr_wraddr),
        .wr_length        (wr_length),
        .ddr_wr_ack       (ddr_wr_ack),
        .ddr_din          (ddr_din),
        .ddr_wr_finish    (ddr_wr_finish),
        .ddr_rd_req       (ddr_rd_req),
        .ddr_rdaddr       (ddr_rdaddr),
        .rd_length        (rd_length),
        .ddr_rd_ack       (ddr_rd_ack),
        .ddr_dout         (ddr_dout),
        .ddr_rd_finish    (ddr_rd_finish),
        .local_address    (local_address),
        .local_write_req  (local_write_req),
        .local_read_req   (local_read_req),
        .local_wdata      (local_wdata),
        .local_ready      (local_ready),
        .local_rdata      (local_rdata),
        .local_rdata_valid(local_rdata_valid),
        .busy             (busy),
        .protocol_err     (protocol_err)
    );

    always #5 clk_ref = ~clk_ref;

    // 0: always ready, 1: ready one cycle in three, other: random
    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one write burst; caller is positioned just after a falling edge.
    task automatic run_write(input logic [ADDR_W-1:0] base, input int len, input int mode,
                             input bit hold_req);
        logic [DATA_W-1:0] data[$];
        logic [DATA_W-1:0] exp_data;
        logic [ADDR_W-1:0] exp_addr;
        int  acks = 0, accepted = 0, din_idx = 0, fin_cnt = 0, fin_cyc = -1;
        int  last_acc = 0, low_cyc = -1, max_out = 0, exp_fin;
        bit  prev_ack = 0, bad_excl = 0;
        for (int i = 0; i < len; i++) data.push_back($urandom);
        ddr_wraddr = base;
        wr_length  = LEN_W'(len);
        ddr_wr_req = 1'b1;
        for (int cyc = 1; cyc <= Budget && low_cyc < 0; cyc++) begin
            @(negedge clk_ref);
            if (prev_ack && din_idx < len) begin
                ddr_din = data[din_idx];
                din_idx++;
            end
            local_ready = pick_ready(mode, cyc);
            #1;
            if (busy && !hold_req) ddr_wr_req = 1'b0;
            prev_ack = ddr_wr_ack;
            if (ddr_wr_ack) acks++;
            if (local_read_req || ddr_rd_ack || ddr_rd_finish) bad_excl = 1;
            if (local_write_req && local_ready) begin
                exp_addr = base + ADDR_W'(accepted);
                exp_data = (accepted < len) ? data[accepted] : 'x;
                total_cnt++;
                if (local_address !== exp_addr || local_wdata !== exp_data)
                    $display("FAIL wr_word[%0d]: got addr=%h data=%h, need addr=%h data=%h",
                             accepted, local_address, local_wdata, exp_addr, exp_data);
                else pass_cnt++;
                accepted++;
                last_acc = cyc;
            end
            if (acks - accepted > max_out) max_out = acks - accepted;
            if (ddr_wr_finish) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
            if (fin_cnt > 0 && !busy) low_cyc = cyc;
        end
        local_ready = 1'b0;
        exp_fin = (len == 0) ? 1 : last_acc + 1;
        total_cnt++;
        if (accepted != len || acks != len)
            $display("FAIL wr_counts: got acks=%0d accepts=%0d, need %0d each", acks, accepted, len);
        else pass_cnt++;
        total_cnt++;
        if (fin_cnt != 1 || fin_cyc != exp_fin)
            $display("FAIL wr_finish: got %0d pulses at cycle %0d, need 1 at cycle %0d",
                     fin_cnt, fin_cyc, exp_fin);
        else pass_cnt++;
        total_cnt++;
        if (low_cyc != fin_cyc + HOLD_CYC)
            $display("FAIL wr_hold: busy low at cycle %0d, need %0d", low_cyc, fin_cyc + HOLD_CYC);
        else pass_cnt++;
        total_cnt++;
        if (max_out > 2 || bad_excl)
            $display("FAIL wr_flow: max unconsumed acks=%0d read activity=%0b, need <=2 and 0",
                     max_out, bad_excl);
        else pass_cnt++;
    endtask

    // Drive one read burst against a fixed-latency DDR model; abort_after>0 stops
    // early (just after that many acks) leaving the DUT mid-burst.
    task automatic run_read(input logic [ADDR_W-1:0] base, input int len, input int mode,
                            input int lat, input int abort_after);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] ret_q[$];
        logic [DATA_W-1:0] exp_data, d;
        logic [ADDR_W-1:0] exp_addr;
        int  due_q[$];
        int  issued = 0, acks = 0, fin_cnt = 0, fin_cyc = -1, last_ack = 0, low_cyc = -1, exp_fin;
        bit  prev_valid = 0, bad_timing = 0, bad_excl = 0, aborted = 0;
        ddr_rdaddr = base;
        rd_length  = LEN_W'(len);
        ddr_rd_req = 1'b1;
        for (int cyc = 1; cyc <= Budget && low_cyc < 0 && !aborted; cyc++) begin
            @(negedge clk_ref);
            local_rdata_valid = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                local_rdata_valid = 1'b1;
                local_rdata = ret_q.pop_front();
            end
            local_ready = pick_ready(mode, cyc);
            #1;
            if (busy) ddr_rd_req = 1'b0;
            if (ddr_rd_ack !== prev_valid) bad_timing = 1;
            prev_valid = local_rdata_valid;
            if (local_write_req || ddr_wr_ack || ddr_wr_finish) bad_excl = 1;
            if (ddr_rd_ack) begin
                exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total_cnt++;
                if (ddr_dout !== exp_data)
                    $display("FAIL rd_word[%0d]: got %h, need %h", acks, ddr_dout, exp_data);
                else pass_cnt++;
                acks++;
                last_ack = cyc;
                if (acks == abort_after) aborted = 1;
            end
            if (local_read_req && local_ready) begin
                exp_addr = base + ADDR_W'(issued);
                total_cnt++;
                if (local_address !== exp_addr || issued >= len)
                    $display("FAIL rd_cmd[%0d]: got addr=%h, need %h (len %0d)",
                             issued, local_address, exp_addr, len);
                else pass_cnt++;
                d = $urandom;
                due_q.push_back(cyc + lat);
                ret_q.push_back(d);
                exp_q.push_back(d);
                issued++;
            end
            if (ddr_rd_finish) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
            if (fin_cnt > 0 && !busy) low_cyc = cyc;
        end
        local_ready = 1'b0;
        local_rdata_valid = 1'b0;
        if (abort_after > 0) begin
            total_cnt++;
            if (!aborted || fin_cnt != 0)
                $display("FAIL rd_abort_point: got %0d acks %0d finishes, need %0d and 0",
                         acks, fin_cnt, abort_after);
            else pass_cnt++;
            return;
        end
        exp_fin = (len == 0) ? 1 : last_ack + 1;
        total_cnt++;
        if (issued != len || acks != len || exp_q.size() != 0)
            $display("FAIL rd_counts: got cmds=%0d acks=%0d, need %0d each", issued, acks, len);
        else pass_cnt++;
        total_cnt++;
        if (fin_cnt != 1 || fin_cyc != exp_fin)
            $display("FAIL rd_finish: got %0d pulses at cycle %0d, need 1 at cycle %0d",
                     fin_cnt, fin_cyc, exp_fin);
        else pass_cnt++;
        total_cnt++;
        if (low_cyc != fin_cyc + HOLD_CYC)
            $display("FAIL rd_hold: busy low at cycle %0d, need %0d", low_cyc, fin_cyc + HOLD_CYC);
        else pass_cnt++;
        total_cnt++;
        if (bad_timing || bad_excl)
            $display("FAIL rd_flow: ack latency error=%0b write activity=%0b, need 0 and 0",
                     bad_timing, bad_excl);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total_cnt++;
        if ({ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_dout, ddr_rd_finish, local_address,
             local_write_req, local_read_req, local_wdata, busy, protocol_err} !== '0)
            $display("FAIL reset_outputs: got busy=%b wr_ack=%b rd_ack=%b err=%b, need all 0",
                     busy, ddr_wr_ack, ddr_rd_ack, protocol_err);
        else pass_cnt++;
        repeat (3) @(negedge clk_ref);
        rst_n = 1'b1;
        local_init_done = 1'b1;
        @(negedge clk_ref);
        #1;
    endtask

    task automatic test_init_done_gate();
        bit seen = 0;
        local_init_done = 1'b0;
        ddr_wraddr = 25'h10;
        wr_length = 10'd4;
        ddr_rd_req = 1'b1;
        ddr_wr_req = 1'b1;
        rd_length = 10'd4;
        repeat (10) begin
            @(negedge clk_ref);
            #1;
            if (busy || local_write_req || local_read_req || ddr_wr_ack) seen = 1;
        end
        total_cnt++;
        if (seen) $display("FAIL init_gate: got activity=1, need 0 while init not done");
        else pass_cnt++;
        ddr_wr_req = 1'b0;
        ddr_rd_req = 1'b0;
        local_init_done = 1'b1;
    endtask

    task automatic test_write();
        run_write(25'h100, 8, 0, 0);
        run_write(25'h100, 8, 1, 0);
        run_write(25'h1FF_FFFD, 6, 2, 0);
        for (int i = 0; i < 3; i++) run_write(ADDR_W'($urandom), $urandom_range(1, 20), 2, 0);
    endtask

    task automatic test_read();
        run_read(25'h200, 16, 0, 5, 0);
        for (int i = 0; i < 3; i++)
            run_read(ADDR_W'($urandom), $urandom_range(1, 20), 2, $urandom_range(1, 8), 0);
    endtask

    task automatic test_zero_len();
        run_write(25'h55, 0, 0, 0);
        run_read(25'h66, 0, 0, 5, 0);
    endtask

    task automatic test_back_to_back();
        // Both requests in one cycle: write must go first, read follows after HOLD
        ddr_rdaddr = 25'h300;
        rd_length = 10'd4;
        ddr_rd_req = 1'b1;
        run_write(25'h180, 4, 0, 0);
        run_read(25'h300, 4, 0, 3, 0);
        // Request held through HOLD: next burst only after HOLD ends
        run_write(25'h400, 3, 0, 1);
        run_write(25'h500, 3, 0, 0);
    endtask

    task automatic test_reset_mid_read();
        run_read(25'h200, 16, 0, 5, 8);
        ddr_rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_dout, ddr_rd_finish, local_address,
             local_write_req, local_read_req, local_wdata, busy, protocol_err} !== '0)
            $display("FAIL reset_mid_read: got busy=%b rd_req=%b rd_ack=%b dout=%h, need all 0",
                     busy, local_read_req, ddr_rd_ack, ddr_dout);
        else pass_cnt++;
        @(negedge clk_ref);
        rst_n = 1'b1;
        @(negedge clk_ref);
        #1;
    endtask

    task automatic test_stray_valid();
        bit acked = 0;
        local_rdata = 32'hDEAD_BEEF;
        local_rdata_valid = 1'b1;
        @(negedge clk_ref);
        local_rdata_valid = 1'b0;
        #1;
        if (ddr_rd_ack) acked = 1;
        total_cnt++;
        if (protocol_err !== 1'b1 || acked || busy)
            $display("FAIL stray_valid: got err=%b ack=%b busy=%b, need 1 0 0",
                     protocol_err, acked, busy);
        else pass_cnt++;
        repeat (3) @(negedge clk_ref);
        #1;
        total_cnt++;
        if (protocol_err !== 1'b1)
            $display("FAIL err_sticky: got %b, need 1", protocol_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_init_done_gate();
        test_write();
        test_read();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_read();
        total_cnt++;
        if (protocol_err !== 1'b0) $display("FAIL err_after_reset: got %b, need 0", protocol_err);
        else pass_cnt++;
        test_stray_valid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
